// File: rtl/sys_defs.sv
// Shared system definitions for the branch reservation station.
// Holds the machine widths, the default station depth, the branch function
// encoding, the packet carried from dispatch to the branch unit, and the
// CDB wakeup helper used for both stored entries and dispatch forwarding.
package sys_defs;

    localparam int XLEN               = 32;  // architectural data width
    localparam int PRF_LEN            = 6;   // physical register index width
    localparam int ROB_LEN            = 5;   // reorder buffer index width
    localparam int DEF_RS_BRANCH_SIZE = 4;   // default number of RS entries

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5,
        BR_JAL  = 3'd6,
        BR_JALR = 3'd7
    } br_func_t;

    typedef struct packed {
        logic [XLEN-1:0]    PC;
        logic [XLEN-1:0]    offset;
        br_func_t           func;
        logic               cond_branch;
        logic [PRF_LEN-1:0] opa_preg_idx;
        logic [XLEN-1:0]    opa_value;
        logic               opa_ready;
        logic [PRF_LEN-1:0] opb_preg_idx;
        logic [XLEN-1:0]    opb_value;
        logic               opb_ready;
        logic [PRF_LEN-1:0] dest_preg_idx;
        logic [ROB_LEN-1:0] rob_idx;
    } RS_BRANCH_PACKET;

    // Capture a CDB broadcast into any operand still waiting on that tag.
    // Operands already ready are left alone; tag 0 is an ordinary tag.
    function automatic RS_BRANCH_PACKET cdb_wakeup(
        input RS_BRANCH_PACKET    pkt,
        input logic               cdb_vld,
        input logic [PRF_LEN-1:0] cdb_tag,
        input logic [XLEN-1:0]    cdb_val
    );
        RS_BRANCH_PACKET res;
        res = pkt;
        if (cdb_vld && !pkt.opa_ready && (pkt.opa_preg_idx == cdb_tag)) begin
            res.opa_value = cdb_val;
            res.opa_ready = 1'b1;
        end
        if (cdb_vld && !pkt.opb_ready && (pkt.opb_preg_idx == cdb_tag)) begin
            res.opb_value = cdb_val;
            res.opb_ready = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_branch_ps_lowest.sv
// Lowest-index priority selector.
// Ports:
//   req_i   [WIDTH] request vector
//   gnt_o   [WIDTH] one-hot grant of the lowest set request bit (zero if none)
//   found_o         at least one request bit is set
module ps_lowest #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic             found_o
);

    // Two's complement isolates the lowest set bit.
    assign gnt_o   = req_i & (~req_i + WIDTH'(1));
    assign found_o = |req_i;

endmodule

// File: rtl/rs_branch.sv
// Branch reservation station.
// Buffers dispatched branch instructions until both operands are ready,
// snoops the CDB for operand values, and issues one instruction at a time
// to the branch unit with a one-cycle strobe.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   dispatch_valid       new branch presented this cycle
//   dispatch_packet      fields of the new branch
//   cdb_valid            CDB broadcast valid this cycle
//   cdb_preg_idx         broadcast physical register tag
//   cdb_value            broadcast value
//   br_busy              branch unit still holds an un-broadcast result
//   squash               mispredict flush, discards all entries
//   rs_branch_full       no free entry (from registered valid bits only)
//   branch_enable        one-cycle issue strobe
//   rs_branch_packet     last issued instruction, held until the next issue
module rs_branch
    import sys_defs::*;
#(
    parameter int RS_BRANCH_SIZE = DEF_RS_BRANCH_SIZE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dispatch_valid,
    input  RS_BRANCH_PACKET    dispatch_packet,
    input  logic               cdb_valid,
    input  logic [PRF_LEN-1:0] cdb_preg_idx,
    input  logic [XLEN-1:0]    cdb_value,
    input  logic               br_busy,
    input  logic               squash,
    output logic               rs_branch_full,
    output logic               branch_enable,
    output RS_BRANCH_PACKET    rs_branch_packet
);

    logic [RS_BRANCH_SIZE-1:0] valid_q, valid_d;
    RS_BRANCH_PACKET           entry_q [RS_BRANCH_SIZE];
    RS_BRANCH_PACKET           entry_d [RS_BRANCH_SIZE];
    logic                      branch_enable_q;
    RS_BRANCH_PACKET           packet_q;

    logic [RS_BRANCH_SIZE-1:0] alloc_gnt, issue_req, issue_gnt;
    logic                      alloc_found, issue_found, issue_go;
    RS_BRANCH_PACKET           issue_pkt;

    // Allocation and selection both look only at registered state, so a
    // slot freed by issue cannot be refilled until the following cycle.
    ps_lowest #(.WIDTH(RS_BRANCH_SIZE)) u_alloc_sel (
        .req_i   (~valid_q),
        .gnt_o   (alloc_gnt),
        .found_o (alloc_found)
    );

    always_comb begin
        for (int i = 0; i < RS_BRANCH_SIZE; i++) begin
            issue_req[i] = valid_q[i] & entry_q[i].opa_ready & entry_q[i].opb_ready;
        end
    end

    ps_lowest #(.WIDTH(RS_BRANCH_SIZE)) u_issue_sel (
        .req_i   (issue_req),
        .gnt_o   (issue_gnt),
        .found_o (issue_found)
    );

    // Blocking on branch_enable_q keeps at least one idle cycle between issues.
    assign issue_go = issue_found & ~br_busy & ~branch_enable_q & ~squash;

    always_comb begin
        issue_pkt = '0;
        for (int i = 0; i < RS_BRANCH_SIZE; i++) begin
            if (issue_gnt[i]) issue_pkt = entry_q[i];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < RS_BRANCH_SIZE; i++) begin
            entry_d[i] = entry_q[i];
            if (valid_q[i]) begin
                entry_d[i] = cdb_wakeup(entry_q[i], cdb_valid, cdb_preg_idx, cdb_value);
            end
            // alloc_found is exactly !rs_branch_full
            if (dispatch_valid && alloc_found && alloc_gnt[i]) begin
                valid_d[i] = 1'b1;
                entry_d[i] = cdb_wakeup(dispatch_packet, cdb_valid, cdb_preg_idx, cdb_value);
            end
            if (issue_go && issue_gnt[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (squash) valid_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q         <= '0;
            branch_enable_q <= 1'b0;
            packet_q        <= '0;
        end else begin
            valid_q         <= valid_d;
            branch_enable_q <= issue_go;
            if (issue_go) packet_q <= issue_pkt;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < RS_BRANCH_SIZE; i++) begin
            entry_q[i] <= entry_d[i];
        end
    end

    assign rs_branch_full   = &valid_q;
    assign branch_enable    = branch_enable_q;
    assign rs_branch_packet = packet_q;

endmodule

// File: tb/tb_rs_branch.sv
module tb_rs_branch;
    import sys_defs::*;

    localparam int N = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               dispatch_valid;
    RS_BRANCH_PACKET    dispatch_packet;
    logic               cdb_valid;
    logic [PRF_LEN-1:0] cdb_preg_idx;
    logic [XLEN-1:0]    cdb_value;
    logic               br_busy;
    logic               squash;
    logic               rs_branch_full;
    logic               branch_enable;
    RS_BRANCH_PACKET    rs_branch_packet;

    always #5 clock = ~clock;

    rs_branch #(.RS_BRANCH_SIZE(N)) dut (
        .clock            (clock),
        .reset            (reset),
        .dispatch_valid   (dispatch_valid),
        .dispatch_packet  (dispatch_packet),
        .cdb_valid        (cdb_valid),
        .cdb_preg_idx     (cdb_preg_idx),
        .cdb_value        (cdb_value),
        .br_busy          (br_busy),
        .squash           (squash),
        .rs_branch_full   (rs_branch_full),
        .branch_enable    (branch_enable),
        .rs_branch_packet (rs_branch_packet)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a table of N optional entries plus the last issued packet.
    RS_BRANCH_PACKET exp_q[$];
    bit              m_valid [N];
    RS_BRANCH_PACKET m_ent   [N];
    bit              m_be;
    RS_BRANCH_PACKET m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_pkt(input string name, input RS_BRANCH_PACKET act, input RS_BRANCH_PACKET exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_full();
        bit f = 1'b1;
        for (int i = 0; i < N; i++) f &= m_valid[i];
        return f;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_be   = 1'b0;
        m_last = '0;
        exp_q.delete();
    endtask

    // Operand capture as the model sees it: a waiting operand takes the value.
    function automatic RS_BRANCH_PACKET m_snoop(input RS_BRANCH_PACKET p, input bit cv,
                                                input logic [PRF_LEN-1:0] tag, input logic [XLEN-1:0] val);
        RS_BRANCH_PACKET r = p;
        if (cv && !r.opa_ready && r.opa_preg_idx == tag) begin r.opa_ready = 1'b1; r.opa_value = val; end
        if (cv && !r.opb_ready && r.opb_preg_idx == tag) begin r.opb_ready = 1'b1; r.opb_value = val; end
        return r;
    endfunction

    task automatic m_step(input bit dv, input RS_BRANCH_PACKET dp, input bit cv,
                          input logic [PRF_LEN-1:0] tag, input logic [XLEN-1:0] val,
                          input bit busy, input bit sq);
        int iss  = -1;
        int slot = -1;
        if (sq) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_be = 1'b0;
            return;
        end
        if (!busy && !m_be)
            for (int i = 0; i < N; i++)
                if (iss < 0 && m_valid[i] && m_ent[i].opa_ready && m_ent[i].opb_ready) iss = i;
        if (dv)
            for (int i = 0; i < N; i++)
                if (slot < 0 && !m_valid[i]) slot = i;
        if (iss >= 0) begin
            exp_q.push_back(m_ent[iss]);
            m_last = m_ent[iss];
        end
        for (int i = 0; i < N; i++)
            if (m_valid[i]) m_ent[i] = m_snoop(m_ent[i], cv, tag, val);
        if (slot >= 0) begin
            m_ent[slot]   = m_snoop(dp, cv, tag, val);
            m_valid[slot] = 1'b1;
        end
        if (iss >= 0) m_valid[iss] = 1'b0;
        m_be = (iss >= 0);
    endtask

    // Drive one cycle of inputs, advance the model, then compare at the negedge.
    task automatic cyc(input bit dv, input RS_BRANCH_PACKET dp, input bit cv,
                       input logic [PRF_LEN-1:0] tag, input logic [XLEN-1:0] val,
                       input bit busy, input bit sq);
        dispatch_valid  = dv;
        dispatch_packet = dp;
        cdb_valid       = cv;
        cdb_preg_idx    = tag;
        cdb_value       = val;
        br_busy         = busy;
        squash          = sq;
        if (reset) m_clear();
        else m_step(dv, dp, cv, tag, val, busy, sq);
        @(posedge clock);
        @(negedge clock);
        chk("full", 64'(rs_branch_full), 64'(m_full()));
        chk("branch_enable", 64'(branch_enable), 64'(m_be));
        chk_pkt("held_packet", rs_branch_packet, m_last);
    endtask

    task automatic idle(input bit busy = 1'b0);
        cyc(1'b0, '0, 1'b0, '0, '0, busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    function automatic RS_BRANCH_PACKET mk(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] off,
                                           input logic [PRF_LEN-1:0] ai, input logic ar,
                                           input logic [PRF_LEN-1:0] bi, input logic br,
                                           input logic [ROB_LEN-1:0] rob);
        RS_BRANCH_PACKET p;
        p.PC            = pc;
        p.offset        = off;
        p.func          = BR_BEQ;
        p.cond_branch   = 1'b1;
        p.opa_preg_idx  = ai;
        p.opa_value     = ar ? $urandom : 32'h0;
        p.opa_ready     = ar;
        p.opb_preg_idx  = bi;
        p.opb_value     = br ? $urandom : 32'h0;
        p.opb_ready     = br;
        p.dest_preg_idx = PRF_LEN'($urandom_range(0, 63));
        p.rob_idx       = rob;
        return p;
    endfunction

    function automatic RS_BRANCH_PACKET rand_pkt();
        RS_BRANCH_PACKET p;
        p.PC            = $urandom;
        p.offset        = $urandom;
        p.func          = br_func_t'($urandom_range(0, 7));
        p.cond_branch   = 1'($urandom_range(0, 1));
        p.opa_preg_idx  = PRF_LEN'($urandom_range(0, 7));
        p.opa_value     = $urandom;
        p.opa_ready     = 1'($urandom_range(0, 1));
        p.opb_preg_idx  = PRF_LEN'($urandom_range(0, 7));
        p.opb_value     = $urandom;
        p.opb_ready     = 1'($urandom_range(0, 1));
        p.dest_preg_idx = PRF_LEN'($urandom_range(0, 63));
        p.rob_idx       = ROB_LEN'($urandom_range(0, 31));
        return p;
    endfunction

    // Scoreboard monitor: every issue strobe must match the oldest expected packet.
    initial begin
        forever begin
            @(negedge clock);
            if (branch_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_issue: got rob_idx %0h expected no issue at %0t",
                             rs_branch_packet.rob_idx, $time);
                end else begin
                    chk_pkt("issued_packet", rs_branch_packet, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RS_BRANCH_PACKET p;
        reset = 1'b1;
        dispatch_valid = 1'b0; dispatch_packet = '0; cdb_valid = 1'b0;
        cdb_preg_idx = '0; cdb_value = '0; br_busy = 1'b0; squash = 1'b0;
        m_clear();
        @(negedge clock);
        do_reset();
        chk("reset_full", 64'(rs_branch_full), 64'd0);
        chk("reset_enable", 64'(branch_enable), 64'd0);
        chk("reset_packet_pc", 64'(rs_branch_packet.PC), 64'd0);

        // Ready BEQ issues one cycle after it is written.
        p = mk(32'h100, 32'h20, 6'd1, 1'b1, 6'd2, 1'b1, 5'd3);
        cyc(1'b1, p, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("beq_not_yet", 64'(branch_enable), 64'd0);
        idle();
        chk("beq_enable", 64'(branch_enable), 64'd1);
        chk("beq_pc", 64'(rs_branch_packet.PC), 64'h100);
        chk("beq_offset", 64'(rs_branch_packet.offset), 64'h20);
        chk("beq_rob", 64'(rs_branch_packet.rob_idx), 64'd3);
        chk("beq_full", 64'(rs_branch_full), 64'd0);
        idle();
        chk("beq_one_cycle", 64'(branch_enable), 64'd0);

        // Wakeup two cycles after dispatch, issue on the following edge.
        p = mk(32'h200, 32'h8, 6'd7, 1'b0, 6'd3, 1'b1, 5'd4);
        cyc(1'b1, p, 1'b0, '0, '0, 1'b0, 1'b0);
        idle();
        cyc(1'b0, '0, 1'b1, 6'd7, 32'h55, 1'b0, 1'b0);
        chk("wake_not_yet", 64'(branch_enable), 64'd0);
        idle();
        chk("wake_enable", 64'(branch_enable), 64'd1);
        chk("wake_opa_value", 64'(rs_branch_packet.opa_value), 64'h55);
        chk("wake_rob", 64'(rs_branch_packet.rob_idx), 64'd4);
        idle();

        // Fill all entries, ignored fifth dispatch, free after wakeup + issue.
        do_reset();
        for (int k = 0; k < N; k++)
            cyc(1'b1, mk(32'h300 + 32'(k), 32'h4, PRF_LEN'(10 + k), 1'b0, 6'd1, 1'b1, ROB_LEN'(8 + k)),
                1'b0, '0, '0, 1'b0, 1'b0);
        chk("fill_full", 64'(rs_branch_full), 64'd1);
        cyc(1'b1, mk(32'h3FF, 32'h4, 6'd1, 1'b1, 6'd1, 1'b1, 5'd15), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("fifth_ignored_full", 64'(rs_branch_full), 64'd1);
        chk("fifth_no_issue", 64'(branch_enable), 64'd0);
        cyc(1'b0, '0, 1'b1, 6'd10, 32'h11, 1'b0, 1'b0);
        chk("woken_still_full", 64'(rs_branch_full), 64'd1);
        idle();
        chk("freed_enable", 64'(branch_enable), 64'd1);
        chk("freed_rob", 64'(rs_branch_packet.rob_idx), 64'd8);
        chk("freed_not_full", 64'(rs_branch_full), 64'd0);
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

        // br_busy holds off issue; slots 0 and 2 ready, slot 1 waiting on tag 20.
        do_reset();
        cyc(1'b1, mk(32'h400, 32'h0, 6'd1, 1'b1, 6'd2, 1'b1, 5'd1), 1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b1, mk(32'h404, 32'h0, 6'd20, 1'b0, 6'd2, 1'b1, 5'd2), 1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b1, mk(32'h408, 32'h0, 6'd1, 1'b1, 6'd2, 1'b1, 5'd3), 1'b0, '0, '0, 1'b1, 1'b0);
        idle(1'b1);
        chk("busy_hold_a", 64'(branch_enable), 64'd0);
        idle(1'b1);
        chk("busy_hold_b", 64'(branch_enable), 64'd0);
        idle();
        chk("slot0_enable", 64'(branch_enable), 64'd1);
        chk("slot0_rob", 64'(rs_branch_packet.rob_idx), 64'd1);
        idle();
        chk("gap_enable", 64'(branch_enable), 64'd0);
        idle();
        chk("slot2_enable", 64'(branch_enable), 64'd1);
        chk("slot2_rob", 64'(rs_branch_packet.rob_idx), 64'd3);

        // Same-cycle CDB forwarding into a dispatched operand.
        cyc(1'b1, mk(32'h500, 32'h0, 6'd1, 1'b1, 6'd9, 1'b0, 5'd6), 1'b1, 6'd9, 32'hAB, 1'b0, 1'b0);
        idle();
        chk("fwd_enable", 64'(branch_enable), 64'd1);
        chk("fwd_opb_value", 64'(rs_branch_packet.opb_value), 64'hAB);
        chk("fwd_opb_ready", 64'(rs_branch_packet.opb_ready), 64'd1);
        chk("fwd_rob", 64'(rs_branch_packet.rob_idx), 64'd6);

        // Squash beats dispatch and issue; last issued packet is kept.
        cyc(1'b1, mk(32'h600, 32'h0, 6'd1, 1'b1, 6'd2, 1'b1, 5'd7), 1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b1, mk(32'h604, 32'h0, 6'd1, 1'b1, 6'd2, 1'b1, 5'd9), 1'b0, '0, '0, 1'b0, 1'b1);
        chk("squash_enable", 64'(branch_enable), 64'd0);
        chk("squash_full", 64'(rs_branch_full), 64'd0);
        chk("squash_pkt_rob", 64'(rs_branch_packet.rob_idx), 64'd6);
        chk("squash_pkt_opb", 64'(rs_branch_packet.opb_value), 64'hAB);
        idle();
        chk("squash_after_a", 64'(branch_enable), 64'd0);
        idle();
        chk("squash_after_b", 64'(branch_enable), 64'd0);

        // Randomized traffic against the model, with occasional mid-run reset.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(0, 99) < 55), rand_pkt(),
                    1'($urandom_range(0, 99) < 40), PRF_LEN'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 2));
            end
        end
        idle();
        idle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_branch.md
RS_BRANCH -- requirements
Module: rs_branch

Interface
REQ-001 Parameter RS_BRANCH_SIZE, default 4: number of reservation-station entries (power of two, ≥2).
REQ-002 clock  input  1  system clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled at posedge clock.
REQ-004 dispatch_valid  input  1  a new branch instruction is presented this cycle.
REQ-005 dispatch_packet  input  RS_BRANCH_PACKET  new instruction fields:
  - PC, offset, func, cond_branch
  - opa/opb preg idx, value and ready
  - dest_preg_idx, rob_idx
REQ-006 cdb_valid  input  1  CDB broadcast is valid this cycle.
REQ-007 cdb_preg_idx  input  `PRF_LEN  physical register being broadcast.
REQ-008 cdb_value  input  `XLEN  value being broadcast.
REQ-009 br_busy  input  1  branch unit holds an un-broadcast result (its br_valid).
REQ-010 squash  input  1  mispredict flush; discards all entries.
REQ-011 rs_branch_full  output  1  no free entry; dispatch SHALL NOT be attempted.
REQ-012 branch_enable  output  1  one-cycle issue strobe to the branch unit.
REQ-013 rs_branch_packet  output  RS_BRANCH_PACKET  issued instruction; held stable until the next issue.

Function
REQ-014 Each entry SHALL hold a valid bit plus one RS_BRANCH_PACKET.
REQ-015 Dispatch allocation SHALL write the lowest-index free entry at posedge when dispatch_valid=1 and rs_branch_full=0.
  - A dispatch attempted while rs_branch_full=1 SHALL be ignored.
REQ-016 Wakeup: at posedge with cdb_valid=1, every valid entry whose operand is not ready and whose preg idx equals cdb_preg_idx SHALL capture cdb_value and set that operand's ready bit.
REQ-017 Same-cycle forwarding: if a dispatched operand matches the CDB tag in the same cycle, the entry SHALL be written with cdb_value and ready=1.
REQ-018 An entry is issuable when it is valid and both of its operands are ready.
REQ-019 Selection SHALL pick the lowest-index issuable entry.
REQ-020 Issue SHALL occur at posedge only when all of the following hold:
  - an issuable entry exists
  - br_busy=0
  - branch_enable=0
  - squash=0
REQ-021 On issue, in the same posedge:
  - the selected entry's packet is latched into rs_branch_packet
  - branch_enable is set to 1 for exactly one cycle
  - the selected entry is invalidated
REQ-022 Issue latency: an entry whose operands are already ready at dispatch SHALL issue no earlier than the posedge after dispatch, i.e. branch_enable is high in cycle N+1 for dispatch in cycle N, when no other constraint blocks it.
REQ-023 rs_branch_full SHALL be computed from registered valid bits only.
  - An entry freed by issue SHALL NOT be reallocated in that same cycle.
REQ-024 squash=1 SHALL, at posedge:
  - clear all valid bits
  - force branch_enable to 0
  - take priority over any dispatch, wakeup or issue in that cycle
  - leave rs_branch_packet unchanged
REQ-025 Wakeup SHALL NOT affect invalid entries.
  - CDB tag 0 has no special meaning: it is matched like any other tag.

Reset
REQ-026 Reset SHALL force all of the following; reset has priority over all other inputs:
  - all valid bits to 0
  - branch_enable to 0
  - rs_branch_packet to all-zero
  - rs_branch_full to 0
REQ-027 Reset asserted mid-operation SHALL discard pending entries and any issue in that cycle.
  - The first dispatch after reset deassertion SHALL be accepted.

Structure
REQ-028 RS_BRANCH_PACKET, `XLEN, `PRF_LEN, `ROB_LEN and the default RS_BRANCH_SIZE SHALL live in the shared sys_defs package.
REQ-029 The lowest-index priority selector used for both allocation and issue SHALL be one sub-module, ps_lowest, parameterised by width.
  - It outputs a one-hot grant and a found flag.

Verification
REQ-030 Reset, then dispatch a BEQ with both operands ready, PC=0x100, offset=0x20, rob_idx=3 -> branch_enable=1 exactly one cycle later, rs_branch_packet.PC=0x100, rs_branch_full=0.
REQ-031 Dispatch an entry with opa preg 7 not ready; broadcast cdb preg 7, value 0x55, two cycles later -> issue on the posedge after the broadcast, opa_value=0x55.
REQ-032 Fill all 4 entries with operands not ready -> rs_branch_full=1; a 5th dispatch is ignored; after one wakeup plus issue, rs_branch_full=0 on the following cycle.
REQ-033 Hold br_busy=1 with two ready entries in slots 0 and 2 -> no branch_enable; release br_busy -> slot 0 issues, and slot 2 issues no sooner than two cycles later.
REQ-034 Dispatch with opb tag 9 while cdb broadcasts preg 9, value 0xAB, in the same cycle -> entry stored ready with opb_value=0xAB.
REQ-035 Assert squash in the same cycle as a dispatch and an issuable entry -> all entries invalid, branch_enable=0 next cycle, rs_branch_packet unchanged.
